// File: rtl/codificador_hamming_pkg.sv
// Shared constants and reference encoder for the Hamming (8,4) SECDED code.
// The encoder function is the single reference model used by the matching
// decoder and by verification.
package codificador_hamming_pkg;

  localparam int DATA_W = 4;
  localparam int CODE_W = 8;

  // Bit positions inside the codeword (Hamming position i lives at bit i-1;
  // the overall parity bit sits on top).
  localparam int POS_P1 = 0;
  localparam int POS_P2 = 1;
  localparam int POS_D0 = 2;
  localparam int POS_P4 = 3;
  localparam int POS_D1 = 4;
  localparam int POS_D2 = 5;
  localparam int POS_D3 = 6;
  localparam int POS_P8 = 7;

  // Pure combinational 4 -> 8 encoder with even overall parity.
  function automatic logic [CODE_W-1:0] hamming84_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    c         = '0;
    c[POS_D0] = d[0];
    c[POS_D1] = d[1];
    c[POS_D2] = d[2];
    c[POS_D3] = d[3];
    c[POS_P1] = d[0] ^ d[1] ^ d[3];
    c[POS_P2] = d[0] ^ d[2] ^ d[3];
    c[POS_P4] = d[1] ^ d[2] ^ d[3];
    c[POS_P8] = ^c[POS_D3:POS_P1];
    return c;
  endfunction

endpackage

// File: rtl/hamming84_paridad.sv
// Combinational Hamming (8,4) codeword generator: places the data bits at
// their Hamming positions, computes p1/p2/p4 and the even overall parity p8.
module hamming84_paridad
  import codificador_hamming_pkg::*;
(
  input  logic [DATA_W-1:0] dato,
  output logic [CODE_W-1:0] codigo
);

  logic p1;
  logic p2;
  logic p4;

  // Parity bits over the data positions each check bit covers.
  always_comb begin
    p1 = dato[0] ^ dato[1] ^ dato[3];
    p2 = dato[0] ^ dato[2] ^ dato[3];
    p4 = dato[1] ^ dato[2] ^ dato[3];
  end

  // Assemble the codeword; p8 makes the whole word even weight.
  // NOTE: every bit gets a default first so no path can leave a bit unassigned and infer a latch.
  always_comb begin
    codigo         = '0;
    codigo[POS_P1] = p1;
    codigo[POS_P2] = p2;
    codigo[POS_D0] = dato[0];
    codigo[POS_P4] = p4;
    codigo[POS_D1] = dato[1];
    codigo[POS_D2] = dato[2];
    codigo[POS_D3] = dato[3];
    codigo[POS_P8] = p1 ^ p2 ^ dato[0] ^ p4 ^ dato[1] ^ dato[2] ^ dato[3];
  end

endmodule

// File: rtl/codificador_hamming.sv
// Registered Hamming (8,4) SECDED encoder, one codeword per clock, latency 1.
// Optional macro CODIFICADOR_HAMMING_CHECK_EN adds error_interno, a registered
// self-check of the output register (syndrome and overall parity).
module codificador_hamming
  import codificador_hamming_pkg::*;
(
  input  logic              reloj,
  input  logic              reset,
  input  logic [DATA_W-1:0] dato_entrada,
`ifdef CODIFICADOR_HAMMING_CHECK_EN
  output logic              error_interno,
`endif
  output logic [CODE_W-1:0] palabra
);

  logic [CODE_W-1:0] codigo;

  hamming84_paridad u_paridad (
    .dato   (dato_entrada),
    .codigo (codigo)
  );

  // Output register: reset wins over new data, otherwise load every edge.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge reloj) begin
    if (reset) palabra <= '0;
    else       palabra <= codigo;
  end

`ifdef CODIFICADOR_HAMMING_CHECK_EN
  logic s1;
  logic s2;
  logic s4;
  logic paridad_impar;
  logic fallo;

  // Recompute syndrome and overall parity of the registered word.
  always_comb begin
    s1            = palabra[POS_P1] ^ palabra[POS_D0] ^ palabra[POS_D1] ^ palabra[POS_D3];
    s2            = palabra[POS_P2] ^ palabra[POS_D0] ^ palabra[POS_D2] ^ palabra[POS_D3];
    s4            = palabra[POS_P4] ^ palabra[POS_D1] ^ palabra[POS_D2] ^ palabra[POS_D3];
    paridad_impar = ^palabra;
    fallo         = s1 | s2 | s4 | paridad_impar;
  end

  // Flag register: raised the cycle after a corrupted output word is seen.
  always_ff @(posedge reloj) begin
    if (reset) error_interno <= 1'b0;
    else       error_interno <= fallo;
  end

`ifndef SYNTHESIS
  // Simulation-only flag of the same condition.
  always_ff @(posedge reloj) begin
    if (!reset) assert (fallo !== 1'b1);
  end
`endif
`endif

endmodule

// File: tb/tb_codificador_hamming.sv
// Directed self-checking bench for codificador_hamming: reset, hand-computed
// vectors, back-to-back streaming, and a sweep of all 16 nibbles checking the
// code properties (even weight, distinctness, minimum distance 4).
module tb_codificador_hamming;
  import codificador_hamming_pkg::*;

  logic              reloj = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] dato_entrada;
  logic [CODE_W-1:0] palabra;
`ifdef CODIFICADOR_HAMMING_CHECK_EN
  logic              error_interno;
`endif

  int checks = 0;
  int errors = 0;

  // Hand-computed codewords for nibbles 0..15.
  logic [CODE_W-1:0] tabla [16] = '{
    8'h00, 8'h87, 8'h99, 8'h1E, 8'hAA, 8'h2D, 8'h33, 8'hB4,
    8'h4B, 8'hCC, 8'hD2, 8'h55, 8'hE1, 8'h66, 8'h78, 8'hFF
  };
  logic [CODE_W-1:0] salidas [16];

  codificador_hamming dut (
    .reloj        (reloj),
    .reset        (reset),
    .dato_entrada (dato_entrada),
`ifdef CODIFICADOR_HAMMING_CHECK_EN
    .error_interno(error_interno),
`endif
    .palabra      (palabra)
  );

  always #5 reloj = ~reloj;

  task automatic check(input string tag, input logic [CODE_W-1:0] observed,
                       input logic [CODE_W-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_true(input string tag, input logic cond);
    checks++;
    assert (cond === 1'b1)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=1", tag, cond);
    end
  endtask

  // Advance one rising edge and settle past it before sampling.
  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    dato_entrada = 4'b1111;

    // Reset held for two edges with all-ones data: output stays zero.
    tick();
    check("reset_edge1", palabra, 8'h00);
    tick();
    check("reset_edge2", palabra, 8'h00);

    // First valid codeword one edge after deassert.
    reset = 1'b0;
    tick();
    check("post_reset_F", palabra, 8'hFF);

    dato_entrada = 4'b1010;
    tick();
    check("vec_1010", palabra, 8'hD2);

    dato_entrada = 4'b0010;
    tick();
    check("vec_0010", palabra, 8'h99);

    dato_entrada = 4'b1101;
    tick();
    check("vec_1101", palabra, 8'h66);

    // Reset mid-stream discards the pending codeword and beats new data.
    dato_entrada = 4'b1010;
    reset        = 1'b1;
    tick();
    check("reset_priority", palabra, 8'h00);
    reset = 1'b0;

    // Back-to-back nibbles on consecutive edges.
    dato_entrada = 4'h0;
    tick();
    check("b2b_0", palabra, 8'h00);
    dato_entrada = 4'hF;
    tick();
    check("b2b_F", palabra, 8'hFF);
    dato_entrada = 4'hA;
    tick();
    check("b2b_A", palabra, 8'hD2);

    // Exhaustive sweep against the hand table and the shared reference.
    for (int i = 0; i < 16; i++) begin
      dato_entrada = 4'(i);
      tick();
      salidas[i] = palabra;
      check($sformatf("sweep_tabla_%0d", i), palabra, tabla[i]);
      check($sformatf("sweep_ref_%0d", i), palabra, hamming84_encode(4'(i)));
      check_true($sformatf("sweep_even_%0d", i), ($countones(palabra) % 2) == 0);
`ifdef CODIFICADOR_HAMMING_CHECK_EN
      check_true($sformatf("sweep_err_low_%0d", i), error_interno == 1'b0);
`endif
    end

    // Pairwise distance >= 4 implies all 16 codewords are distinct.
    for (int i = 0; i < 16; i++) begin
      for (int j = i + 1; j < 16; j++) begin
        check_true($sformatf("dist_%0d_%0d", i, j),
                   $countones(salidas[i] ^ salidas[j]) >= 4);
      end
    end

`ifdef CODIFICADOR_HAMMING_CHECK_EN
    // Corrupt one bit of the output register and expect the flag next cycle.
    dato_entrada = 4'hA;
    tick();
    check_true("err_before_force", error_interno == 1'b0);
    force dut.palabra = 8'hD2 ^ 8'h10;
    tick();
    check_true("err_after_force", error_interno == 1'b1);
    release dut.palabra;
    tick();
    tick();
    check_true("err_after_release", error_interno == 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
